// File: rtl/chan_mux_n_if.sv
// Channel bundle for chan_mux_n: N input channels, the select token and the buffered output.
interface chan_mux_n_if #(
    parameter int unsigned WIDTH = 11,
    parameter int unsigned N     = 4,
    parameter int unsigned SEL_W = 2
);
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [SEL_W-1:0]   sel_data;
    logic               sel_valid;
    logic               sel_ready;
    logic [WIDTH-1:0]   out_data;
    logic [SEL_W-1:0]   out_src;
    logic               out_valid;
    logic               out_ready;
    logic               err_sel;

    modport master (
        output in_data, in_valid, sel_data, sel_valid, out_ready,
        input  in_ready, sel_ready, out_data, out_src, out_valid, err_sel
    );

    modport slave (
        input  in_data, in_valid, sel_data, sel_valid, out_ready,
        output in_ready, sel_ready, out_data, out_src, out_valid, err_sel
    );
endinterface

// File: rtl/chan_mux_n.sv
// N-way channel multiplexer with a 2-entry {src, data} output buffer.
// MODE 0: a select token routes one word from the chosen input.
// MODE 1: round-robin arbitration across valid inputs; select channel ignored.
module chan_mux_n #(
    parameter int unsigned WIDTH = 11,
    parameter int unsigned N     = 4,
    parameter int unsigned SEL_W = 2,
    parameter int unsigned MODE  = 0
) (
    input logic         clk,
    input logic         rst_n,
    chan_mux_n_if.slave bus
);
    logic [WIDTH-1:0] data_q [2];
    logic [SEL_W-1:0] src_q  [2];
    logic             rd_ptr_q, wr_ptr_q;
    logic [1:0]       count_q, count_d;
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             err_q;

    logic             space, push, pop, drop;
    logic [SEL_W-1:0] push_src;
    logic [WIDTH-1:0] push_data;
    logic [N-1:0]     in_ready;
    logic             sel_ready;

    logic             sel_in_range, sel_in_valid;
    logic [WIDTH-1:0] sel_in_data;
    logic             rr_found;
    logic [SEL_W-1:0] rr_grant;
    logic [WIDTH-1:0] rr_data;
    int unsigned      rr_best, rr_dist;

    // Decode the select token; an index matching no channel is out of range.
    always_comb begin
        sel_in_range = 1'b0;
        sel_in_valid = 1'b0;
        sel_in_data  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (bus.sel_data == SEL_W'(i)) begin
                sel_in_range = 1'b1;
                sel_in_valid = bus.in_valid[i];
                sel_in_data  = bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Round-robin grant: valid channel with the smallest distance from rr_ptr.
    always_comb begin
        rr_found = 1'b0;
        rr_grant = '0;
        rr_data  = '0;
        rr_best  = N;
        rr_dist  = 0;
        for (int unsigned i = 0; i < N; i++) begin
            // rr_ptr_q < N always, so this never underflows
            rr_dist = (i + N - 32'(rr_ptr_q)) % N;
            if (bus.in_valid[i] && rr_dist < rr_best) begin
                rr_best  = rr_dist;
                rr_found = 1'b1;
                rr_grant = SEL_W'(i);
                rr_data  = bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Accept/drop decision, readies, buffer occupancy and arbiter pointer update.
    always_comb begin
        space     = (count_q != 2'd2);
        push      = 1'b0;
        drop      = 1'b0;
        push_src  = '0;
        push_data = '0;
        sel_ready = 1'b0;
        in_ready  = '0;
        rr_ptr_d  = rr_ptr_q;
        // readies are forced low while reset is held
        if (rst_n) begin
            if (MODE == 0) begin
                if (bus.sel_valid && !sel_in_range) begin
                    sel_ready = 1'b1;
                    drop      = 1'b1;
                end else if (bus.sel_valid && sel_in_valid && space) begin
                    sel_ready = 1'b1;
                    push      = 1'b1;
                    push_src  = bus.sel_data;
                    push_data = sel_in_data;
                end
            end else if (rr_found && space) begin
                push      = 1'b1;
                push_src  = rr_grant;
                push_data = rr_data;
                rr_ptr_d  = SEL_W'((32'(rr_grant) + 1) % N);
            end
        end
        for (int unsigned i = 0; i < N; i++) begin
            in_ready[i] = push && (push_src == SEL_W'(i));
        end
        pop     = (count_q != 2'd0) && bus.out_ready;
        count_d = count_q + {1'b0, push} - {1'b0, pop};
    end

    // Buffer storage, pointers, arbiter state and the bad-select pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q[0] <= '0;
            data_q[1] <= '0;
            src_q[0]  <= '0;
            src_q[1]  <= '0;
            rd_ptr_q  <= 1'b0;
            wr_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
            rr_ptr_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            if (push) begin
                data_q[wr_ptr_q] <= push_data;
                src_q[wr_ptr_q]  <= push_src;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q  <= count_d;
            rr_ptr_q <= rr_ptr_d;
            err_q    <= drop;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.sel_ready = sel_ready;
    assign bus.out_data  = data_q[rd_ptr_q];
    assign bus.out_src   = src_q[rd_ptr_q];
    assign bus.out_valid = (count_q != 2'd0);
    assign bus.err_sel   = err_q;
endmodule

// File: tb/tb_chan_mux_n.sv
// Directed bench for chan_mux_n: select mode (N=4 and N=3) and round-robin mode (N=4).
module tb_chan_mux_n;
    localparam int unsigned W = 11;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    chan_mux_n_if #(.WIDTH(W), .N(4), .SEL_W(2)) if0 ();
    chan_mux_n_if #(.WIDTH(W), .N(3), .SEL_W(2)) if3 ();
    chan_mux_n_if #(.WIDTH(W), .N(4), .SEL_W(2)) if1 ();

    chan_mux_n #(.WIDTH(W), .N(4), .SEL_W(2), .MODE(0)) u_sel4 (
        .clk(clk), .rst_n(rst_n), .bus(if0)
    );
    chan_mux_n #(.WIDTH(W), .N(3), .SEL_W(2), .MODE(0)) u_sel3 (
        .clk(clk), .rst_n(rst_n), .bus(if3)
    );
    chan_mux_n #(.WIDTH(W), .N(4), .SEL_W(2), .MODE(1)) u_rr (
        .clk(clk), .rst_n(rst_n), .bus(if1)
    );

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_all();
        if0.in_data = '0; if0.in_valid = '0; if0.sel_data = '0; if0.sel_valid = 1'b0;
        if0.out_ready = 1'b0;
        if3.in_data = '0; if3.in_valid = '0; if3.sel_data = '0; if3.sel_valid = 1'b0;
        if3.out_ready = 1'b0;
        if1.in_data = '0; if1.in_valid = '0; if1.sel_data = '0; if1.sel_valid = 1'b0;
        if1.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        if0.in_valid = 4'hF; if0.sel_valid = 1'b1; if0.out_ready = 1'b1;
        if0.in_data = {4{11'h5A5}};
        if1.in_valid = 4'hF; if1.out_ready = 1'b1;
        repeat (3) tick();
        total++; if (if0.out_valid !== 1'b0) begin
            bad++; $display("FAIL reset_out_valid got=%0b exp=0", if0.out_valid); end
        total++; if (if0.out_data !== 11'h000) begin
            bad++; $display("FAIL reset_out_data got=%h exp=000", if0.out_data); end
        total++; if (if0.out_src !== 2'd0) begin
            bad++; $display("FAIL reset_out_src got=%0d exp=0", if0.out_src); end
        total++; if (if0.in_ready !== 4'b0000) begin
            bad++; $display("FAIL reset_in_ready got=%b exp=0000", if0.in_ready); end
        total++; if (if0.sel_ready !== 1'b0) begin
            bad++; $display("FAIL reset_sel_ready got=%0b exp=0", if0.sel_ready); end
        total++; if (if1.in_ready !== 4'b0000) begin
            bad++; $display("FAIL reset_rr_in_ready got=%b exp=0000", if1.in_ready); end
        total++; if (if0.err_sel !== 1'b0) begin
            bad++; $display("FAIL reset_err_sel got=%0b exp=0", if0.err_sel); end
        idle_all();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_route();
        if0.out_ready = 1'b1;
        if0.in_data   = {11'h155, 11'b11111000000, 11'h2AA, 11'b00111000001};
        if0.in_valid  = 4'b1111;
        if0.sel_data  = 2'd0;
        if0.sel_valid = 1'b1;
        settle();
        total++; if (if0.in_ready !== 4'b0001) begin
            bad++; $display("FAIL route_rdy0 got=%b exp=0001", if0.in_ready); end
        total++; if (if0.sel_ready !== 1'b1) begin
            bad++; $display("FAIL route_sel_rdy got=%0b exp=1", if0.sel_ready); end
        tick();
        total++; if (if0.out_valid !== 1'b1 || if0.out_data !== 11'b00111000001
                     || if0.out_src !== 2'd0) begin
            bad++; $display("FAIL route_out0 got v=%0b d=%b s=%0d exp v=1 d=00111000001 s=0",
                            if0.out_valid, if0.out_data, if0.out_src); end
        if0.sel_data = 2'd2;
        settle();
        total++; if (if0.in_ready !== 4'b0100) begin
            bad++; $display("FAIL route_rdy2 got=%b exp=0100", if0.in_ready); end
        tick();
        total++; if (if0.out_valid !== 1'b1 || if0.out_data !== 11'b11111000000
                     || if0.out_src !== 2'd2) begin
            bad++; $display("FAIL route_out2 got v=%0b d=%b s=%0d exp v=1 d=11111000000 s=2",
                            if0.out_valid, if0.out_data, if0.out_src); end
        if0.sel_valid = 1'b0;
        settle();
        total++; if (if0.in_ready !== 4'b0000) begin
            bad++; $display("FAIL route_idle_rdy got=%b exp=0000", if0.in_ready); end
        tick();
        total++; if (if0.out_valid !== 1'b0) begin
            bad++; $display("FAIL route_drained got=%0b exp=0", if0.out_valid); end
        idle_all();
    endtask

    task automatic test_bad_sel();
        if3.out_ready = 1'b1;
        if3.in_data   = {11'h123, 11'h7FF, 11'h045};
        if3.in_valid  = 3'b111;
        if3.sel_data  = 2'd3;
        if3.sel_valid = 1'b1;
        settle();
        total++; if (if3.sel_ready !== 1'b1) begin
            bad++; $display("FAIL badsel_sel_rdy got=%0b exp=1", if3.sel_ready); end
        total++; if (if3.in_ready !== 3'b000) begin
            bad++; $display("FAIL badsel_in_rdy got=%b exp=000", if3.in_ready); end
        total++; if (if3.err_sel !== 1'b0) begin
            bad++; $display("FAIL badsel_err_early got=%0b exp=0", if3.err_sel); end
        tick();
        if3.sel_valid = 1'b0;
        if3.in_valid  = 3'b000;
        total++; if (if3.err_sel !== 1'b1) begin
            bad++; $display("FAIL badsel_err_pulse got=%0b exp=1", if3.err_sel); end
        total++; if (if3.out_valid !== 1'b0) begin
            bad++; $display("FAIL badsel_no_out got=%0b exp=0", if3.out_valid); end
        tick();
        total++; if (if3.err_sel !== 1'b0) begin
            bad++; $display("FAIL badsel_err_end got=%0b exp=0", if3.err_sel); end
        if3.sel_data  = 2'd1;
        if3.sel_valid = 1'b1;
        if3.in_valid  = 3'b010;
        settle();
        total++; if (if3.in_ready !== 3'b010 || if3.sel_ready !== 1'b1) begin
            bad++; $display("FAIL badsel_next_rdy got in=%b sel=%0b exp in=010 sel=1",
                            if3.in_ready, if3.sel_ready); end
        tick();
        if3.sel_valid = 1'b0;
        total++; if (if3.out_valid !== 1'b1 || if3.out_data !== 11'h7FF
                     || if3.out_src !== 2'd1 || if3.err_sel !== 1'b0) begin
            bad++; $display("FAIL badsel_next_out got v=%0b d=%h s=%0d e=%0b exp v=1 d=7ff s=1 e=0",
                            if3.out_valid, if3.out_data, if3.out_src, if3.err_sel); end
        tick();
        idle_all();
    endtask

    task automatic test_backpressure();
        if0.out_ready = 1'b0;
        if0.sel_data  = 2'd0;
        if0.sel_valid = 1'b1;
        if0.in_valid  = 4'b0001;
        if0.in_data   = {33'h0, 11'h101};
        settle();
        total++; if (if0.in_ready !== 4'b0001) begin
            bad++; $display("FAIL bp_acc1 got=%b exp=0001", if0.in_ready); end
        tick();
        if0.in_data = {33'h0, 11'h202};
        settle();
        total++; if (if0.in_ready !== 4'b0001) begin
            bad++; $display("FAIL bp_acc2 got=%b exp=0001", if0.in_ready); end
        tick();
        if0.in_data = {33'h0, 11'h303};
        settle();
        total++; if (if0.in_ready !== 4'b0000 || if0.sel_ready !== 1'b0) begin
            bad++; $display("FAIL bp_full_rdy got in=%b sel=%0b exp in=0000 sel=0",
                            if0.in_ready, if0.sel_ready); end
        tick();
        total++; if (if0.out_valid !== 1'b1 || if0.out_data !== 11'h101) begin
            bad++; $display("FAIL bp_hold got v=%0b d=%h exp v=1 d=101",
                            if0.out_valid, if0.out_data); end
        if0.out_ready = 1'b1;
        settle();
        total++; if (if0.in_ready !== 4'b0000) begin
            bad++; $display("FAIL bp_no_passthru got=%b exp=0000", if0.in_ready); end
        tick();
        total++; if (if0.out_data !== 11'h202) begin
            bad++; $display("FAIL bp_drain2 got=%h exp=202", if0.out_data); end
        total++; if (if0.in_ready !== 4'b0001) begin
            bad++; $display("FAIL bp_resume got=%b exp=0001", if0.in_ready); end
        tick();
        if0.sel_valid = 1'b0;
        total++; if (if0.out_valid !== 1'b1 || if0.out_data !== 11'h303) begin
            bad++; $display("FAIL bp_third got v=%0b d=%h exp v=1 d=303",
                            if0.out_valid, if0.out_data); end
        tick();
        total++; if (if0.out_valid !== 1'b0) begin
            bad++; $display("FAIL bp_empty got=%0b exp=0", if0.out_valid); end
        idle_all();
    endtask

    task automatic test_round_robin();
        logic [3:0]  vp   [9] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hA, 4'hA, 4'hA, 4'hA};
        int unsigned exps [9] = '{0, 1, 2, 3, 0, 1, 3, 1, 3};
        logic [3:0]  onehot;
        for (int i = 0; i < 4; i++) if1.in_data[i*W +: W] = W'(100 + i);
        if1.out_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            if1.in_valid = vp[k];
            onehot = 4'b0001 << exps[k];
            settle();
            total++; if (if1.in_ready !== onehot) begin
                bad++; $display("FAIL rr_grant step=%0d got=%b exp=%b", k, if1.in_ready, onehot); end
            tick();
            total++; if (if1.out_valid !== 1'b1 || 32'(if1.out_src) !== exps[k]
                         || 32'(if1.out_data) !== 100 + exps[k]) begin
                bad++; $display("FAIL rr_out step=%0d got v=%0b s=%0d d=%0d exp s=%0d d=%0d",
                                k, if1.out_valid, if1.out_src, if1.out_data, exps[k],
                                100 + exps[k]); end
        end
        if1.in_valid = 4'b0000;
        tick();
        total++; if (if1.out_valid !== 1'b0) begin
            bad++; $display("FAIL rr_drained got=%0b exp=0", if1.out_valid); end
    endtask

    task automatic test_reset_mid();
        // fill the buffer with grants 0 and 1, leaving the pointer at 2
        if1.out_ready = 1'b0;
        if1.in_valid  = 4'hF;
        tick();
        tick();
        settle();
        total++; if (if1.in_ready !== 4'b0000 || if1.out_valid !== 1'b1) begin
            bad++; $display("FAIL rstmid_full got in=%b v=%0b exp in=0000 v=1",
                            if1.in_ready, if1.out_valid); end
        rst_n = 1'b0;
        settle();
        total++; if (if1.out_valid !== 1'b0 || if1.in_ready !== 4'b0000) begin
            bad++; $display("FAIL rstmid_clear got v=%0b in=%b exp v=0 in=0000",
                            if1.out_valid, if1.in_ready); end
        tick();
        if1.in_valid  = 4'b0110;
        if1.out_ready = 1'b1;
        rst_n = 1'b1;
        settle();
        total++; if (if1.in_ready !== 4'b0010) begin
            bad++; $display("FAIL rstmid_first_grant got=%b exp=0010", if1.in_ready); end
        tick();
        total++; if (if1.out_valid !== 1'b1 || if1.out_src !== 2'd1 || if1.out_data !== 11'd101)
        begin
            bad++; $display("FAIL rstmid_out got v=%0b s=%0d d=%0d exp v=1 s=1 d=101",
                            if1.out_valid, if1.out_src, if1.out_data); end
        idle_all();
        tick();
    endtask

    initial begin
        idle_all();
        rst_n = 1'b0;
        test_reset();
        test_route();
        test_bad_sel();
        test_backpressure();
        test_round_robin();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/chan_mux_n.md
# chan_mux_n

Clocked, parametrised N-way channel multiplexer for the router datapath. It merges N valid/ready input channels onto one output channel through a 2-entry output buffer, and tags each output word with its source index. Mode 0 is select-driven: one select token routes one data token. Mode 1 is round-robin arbitration. It replaces the fixed 2-input, select-only MUX stage wherever more ports, backpressure buffering or fair arbitration are needed.

## Interface
Parameters:
- WIDTH, 11, data bits per channel
- N, 4, number of input channels (2..16)
- SEL_W, 2, select/source index width; must satisfy 2^SEL_W >= N
- MODE, 0, 0 = select-driven, 1 = round-robin (select channel ignored)

Ports:
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_data  in  N*WIDTH  input channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  in  N  per-channel valid
- in_ready  out  N  per-channel ready
- sel_data  in  SEL_W  select token: index of the input to consume
- sel_valid  in  1  select token valid
- sel_ready  out  1  select token ready
- out_data  out  WIDTH  head-of-buffer data
- out_src  out  SEL_W  source index of out_data
- out_valid  out  1  buffer non-empty
- out_ready  in  1  consumer ready
- err_sel  out  1  one-cycle pulse: out-of-range select token consumed

## Operation
- Transfer on any channel = valid && ready at a rising clk edge.
- Output buffer: 2-entry FIFO of {src, data}, with count 0..2. space = (count < 2). There is no pass-through at full: a pop and a push in the same cycle while count==2 is not possible because space=0.
- MODE 0:
  - Accept when sel_valid && sel_data < N && in_valid[sel_data] && space.
  - On accept, sel_ready=1 and in_ready[sel_data]=1 in the same cycle. The entry {sel_data, in_data[sel_data]} is pushed.
  - If sel_valid && sel_data >= N: sel_ready=1 regardless of space. The token is dropped, nothing is pushed, and err_sel=1 the next cycle.
  - A valid select with its input not valid waits. The select is held and no other input is consumed.
  - Unselected in_ready = 0.
- MODE 1:
  - sel_ready tied 0. err_sel tied 0.
  - rr_ptr (SEL_W bits, reset 0). Grant = first i in order rr_ptr, rr_ptr+1, ... (mod N) with in_valid[i].
  - If space and a grant exists: in_ready[grant]=1 and the entry is pushed. rr_ptr <= (grant+1) mod N.
  - rr_ptr changes only on a grant.
- in_ready/sel_ready are combinational from valids and state. Producers must not make valid depend on ready.
- Pop when out_valid && out_ready. Push and pop in the same cycle keep count unchanged.

## Timing
- Reset values: out_valid=0, out_data=0, out_src=0, err_sel=0, count=0, rr_ptr=0. With rst_n low, all in_ready=0 and sel_ready=0.
- Reset asserted mid-operation clears the buffer immediately. Buffered words are lost.
- Latency: a word accepted at edge k appears with out_valid=1 after edge k, provided the buffer was empty.
- Throughput: 1 word/cycle while out_ready=1. Count stays ≤1.
- With out_ready=0: two words are accepted, then all readies drop. After the first pop, acceptance resumes on the following edge.
- err_sel is high for exactly the cycle after the drop edge.
- out_data/out_src are stable while out_valid && !out_ready.

## Test plan
- Reset/idle:
  - Stimulus: hold rst_n=0 for 3 cycles, with all valids high.
  - Required: out_valid=0, out_data=0, in_ready=0, sel_ready=0.
- MODE 0 routing (N=4, WIDTH=11):
  - Stimulus: in0=11'b00111000001 with sel=0, then in2=11'b11111000000 with sel=2, out_ready=1.
  - Required: out = 11'b00111000001/src 0, then 11'b11111000000/src 2, each 1 cycle after accept.
  - Required: in1/in3 are never readied.
- MODE 0 bad select (N=3, SEL_W=2):
  - Stimulus: sel=3.
  - Required: sel_ready=1, err_sel pulses 1 cycle, no output. A following sel=1 with in1=11'h7FF outputs 11'h7FF/src 1.
- Backpressure:
  - Stimulus: out_ready=0, three words offered on in0.
  - Required: exactly two accepted, then in_ready[0]=0. Raising out_ready drains them in order, then the third is accepted.
- MODE 1 fairness (N=4):
  - Stimulus: all inputs valid continuously, out_ready=1.
  - Required: src sequence 0,1,2,3,0,1... If only inputs 1 and 3 are valid, the sequence is 1,3,1,3.
- Reset mid-stream:
  - Stimulus: drop rst_n with count=2.
  - Required: out_valid=0 immediately, rr_ptr=0. After release, the first grant in MODE 1 is the lowest valid index.
